// File: rtl/phi0_pkg.sv
// Shared types and default sizing for the phi0 clock divider.
// The optional stop-length limit is enabled by PHI0_MAX_STRETCH_EN.
package phi0_pkg;

    typedef enum logic [1:0] {
        LOW     = 2'd0,
        HIGH    = 2'd1,
        STOPPED = 2'd2
    } phi0_state_t;

    localparam int unsigned DEF_DIV_W      = 8;
    localparam int unsigned DEF_RES_CYCLES = 8;
    localparam int unsigned DEF_MAX_STOP   = 255;

endpackage

// File: rtl/res_sequencer.sv
// Holds the CPU reset low for RES_CYCLES clk0 periods after system reset.
// Fed with the next-cycle phi1 strobe so res_n rises alongside it.
module res_sequencer
    import phi0_pkg::*;
#(
    parameter int unsigned RES_CYCLES = DEF_RES_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic phi1_rise,
    output logic res_n
);

    localparam int unsigned CW = $clog2(RES_CYCLES + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            res_n <= 1'b0;
        end else if (!res_n && phi1_rise) begin
            if (cnt == CW'(RES_CYCLES - 1))
                res_n <= 1'b1;
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/phi0_divider.sv
// Divides clk into the 6502 clk0 square wave with phase strobes and stop.
// Define PHI0_MAX_STRETCH_EN to bound stop length to MAX_STOP cycles.
module phi0_divider
    import phi0_pkg::*;
#(
    parameter int unsigned DIV_W      = DEF_DIV_W,
    parameter int unsigned RES_CYCLES = DEF_RES_CYCLES
`ifdef PHI0_MAX_STRETCH_EN
    ,
    parameter int unsigned MAX_STOP   = DEF_MAX_STOP
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] half_period,
    input  logic             stop_req,
    output logic             clk0,
    output logic             phi2_rise,
    output logic             phi1_rise,
    output logic             res_n,
    output logic             stop_ack
);

    phi0_state_t      state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] load_val;
    logic             phase_end;
    logic             phi1_nxt;
    logic             stop_ok;
    logic             stop_exit;

    // A zero half-period behaves like one.
    assign load_val  = (half_period == '0) ? '0
                     : half_period - 1'b1;
    assign phase_end = (cnt == '0);
    assign phi1_nxt  = (state == HIGH) && phase_end;

`ifdef PHI0_MAX_STRETCH_EN
    localparam int unsigned SW = $clog2(MAX_STOP + 1);

    logic [SW-1:0] scnt;
    logic          hold;

    assign stop_ok   = stop_req && res_n && !hold;
    assign stop_exit = !stop_req || (scnt == '0);

    // hold blocks a new stop until stop_req drops after a forced exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            scnt <= '0;
            hold <= 1'b0;
        end else begin
            if (state == LOW && phase_end && stop_ok)
                scnt <= SW'(MAX_STOP - 1);
            else if (state == STOPPED && scnt != '0)
                scnt <= scnt - 1'b1;
            if (state == STOPPED && stop_exit)
                hold <= stop_req;
            else if (!stop_req)
                hold <= 1'b0;
        end
    end
`else
    assign stop_ok   = stop_req && res_n;
    assign stop_exit = !stop_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOW;
            cnt       <= load_val;
            clk0      <= 1'b0;
            phi1_rise <= 1'b0;
            phi2_rise <= 1'b0;
            stop_ack  <= 1'b0;
        end else begin
            phi1_rise <= 1'b0;
            phi2_rise <= 1'b0;
            unique case (state)
                LOW: begin
                    if (!phase_end) begin
                        cnt <= cnt - 1'b1;
                    end else if (stop_ok) begin
                        state    <= STOPPED;
                        stop_ack <= 1'b1;
                    end else begin
                        state     <= HIGH;
                        clk0      <= 1'b1;
                        phi2_rise <= 1'b1;
                        cnt       <= load_val;
                    end
                end
                HIGH: begin
                    if (!phase_end) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state     <= LOW;
                        clk0      <= 1'b0;
                        phi1_rise <= 1'b1;
                        cnt       <= load_val;
                    end
                end
                STOPPED: begin
                    if (stop_exit) begin
                        state     <= HIGH;
                        clk0      <= 1'b1;
                        phi2_rise <= 1'b1;
                        stop_ack  <= 1'b0;
                        cnt       <= load_val;
                    end
                end
                default: begin
                    state    <= LOW;
                    clk0     <= 1'b0;
                    stop_ack <= 1'b0;
                    cnt      <= load_val;
                end
            endcase
        end
    end

    res_sequencer #(
        .RES_CYCLES(RES_CYCLES)
    ) u_res (
        .clk      (clk),
        .rst      (rst),
        .phi1_rise(phi1_nxt),
        .res_n    (res_n)
    );

endmodule

// File: tb/tb_phi0_divider.sv
// Bench for phi0_divider: cycle model plus directed timing checks.
// Build with PHI0_MAX_STRETCH_EN to exercise the bounded stop.
module tb_phi0_divider;

    localparam int RES = 8;
    localparam int MAXS = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] half_period = 8'd3;
    logic       stop_req = 1'b0;
    logic       clk0, phi2_rise, phi1_rise, res_n, stop_ack;

    int asserts = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    phi0_divider #(
        .DIV_W(8),
        .RES_CYCLES(RES)
`ifdef PHI0_MAX_STRETCH_EN
        ,
        .MAX_STOP(MAXS)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .half_period(half_period),
        .stop_req(stop_req),
        .clk0(clk0),
        .phi2_rise(phi2_rise),
        .phi1_rise(phi1_rise),
        .res_n(res_n),
        .stop_ack(stop_ack)
    );

    // Phase-level model: cycles left in phase, level, stop time, reset count
    int m_left, m_nres, m_stop;
    bit m_clk0, m_p1, m_p2, m_resn, m_ack, m_hold;

    function automatic int hp_eff();
        return (half_period == 8'd0) ? 1 : int'(half_period);
    endfunction

    function automatic bit limit_hit(int s);
`ifdef PHI0_MAX_STRETCH_EN
        return s >= MAXS;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_clk0 = 0; m_p1 = 0; m_p2 = 0;
            m_resn = 0; m_ack = 0; m_hold = 0;
            m_nres = 0; m_stop = 0;
            m_left = hp_eff();
        end else begin
            m_p1 = 0; m_p2 = 0;
            if (m_ack) begin
                m_stop++;
                if (!stop_req || limit_hit(m_stop)) begin
                    m_ack = 0; m_clk0 = 1; m_p2 = 1;
                    m_left = hp_eff();
`ifdef PHI0_MAX_STRETCH_EN
                    m_hold = stop_req;
`endif
                end
            end else begin
                if (!stop_req) m_hold = 0;
                m_left--;
                if (m_left == 0) begin
                    if (m_clk0) begin
                        m_clk0 = 0; m_p1 = 1;
                        m_left = hp_eff();
                        if (!m_resn) begin
                            m_nres++;
                            if (m_nres == RES) m_resn = 1;
                        end
                    end else if (stop_req && m_resn && !m_hold) begin
                        m_ack = 1; m_stop = 0;
                    end else begin
                        m_clk0 = 1; m_p2 = 1;
                        m_left = hp_eff();
                    end
                end
            end
            if (m_ack && !stop_req) m_hold = 0;
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        asserts++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("clk0", int'(clk0), int'(m_clk0));
            check("phi2_rise", int'(phi2_rise), int'(m_p2));
            check("phi1_rise", int'(phi1_rise), int'(m_p1));
            check("res_n", int'(res_n), int'(m_resn));
            check("stop_ack", int'(stop_ack), int'(m_ack));
        end
    end

    function automatic bit sel(input int w);
        case (w)
            0: return phi2_rise;
            1: return phi1_rise;
            2: return stop_ack;
            default: return res_n;
        endcase
    endfunction

    // Negedges until the chosen output is seen high; timeout is a failure.
    task automatic wait_sig(input int w, input int lim, output int n);
        bit hit;
        n = 0;
        hit = 0;
        while (!hit && n < lim) begin
            @(negedge clk);
            n++;
            hit = sel(w);
        end
        if (!hit) begin
            asserts++;
            fails++;
            $display("FAIL timeout sig=%0d: got none expected within %0d",
                     w, lim);
        end
    endtask

    int n, ackc;

    initial begin
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst clk0", int'(clk0), 0);
        check("rst phi1", int'(phi1_rise), 0);
        check("rst phi2", int'(phi2_rise), 0);
        check("rst res_n", int'(res_n), 0);
        check("rst ack", int'(stop_ack), 0);

        // reset release with stop requested throughout
        half_period = 8'd2;
        stop_req = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wait_sig(3, 100, n);
        check("res_n delay", n, 32);

        // now a stop is honoured; reset it while STOPPED
        wait_sig(2, 20, n);
        check("stop after res", n, 2);
        rst = 1'b1;
        @(negedge clk);
        check("rst clk0 stp", int'(clk0), 0);
        check("rst ack stp", int'(stop_ack), 0);
        check("rst res_n stp", int'(res_n), 0);
        stop_req = 1'b0;
        half_period = 8'd3;
        @(negedge clk);
        rst = 1'b0;

        // divide by 6
        wait_sig(3, 200, n);
        wait_sig(0, 20, n);
        wait_sig(1, 20, n);
        check("hp3 high", n, 3);
        wait_sig(0, 20, n);
        check("hp3 low", n, 3);

`ifndef PHI0_MAX_STRETCH_EN
        // stop raised in HIGH, held 10 cycles
        @(negedge clk);
        stop_req = 1'b1;
        wait_sig(1, 20, n);
        check("high completes", n, 2);
        wait_sig(2, 20, n);
        check("low before stop", n, 3);
        ackc = 1;
        while (ackc < 10) begin
            @(negedge clk);
            check("ack held", int'(stop_ack), 1);
            check("clk0 held", int'(clk0), 0);
            ackc++;
        end
        stop_req = 1'b0;
        wait_sig(0, 20, n);
        check("resume lat", n, 1);
        check("ack drop", int'(stop_ack), 0);
        check("clk0 up", int'(clk0), 1);
`else
        // stop held: forced exit, then no stop until stop_req drops
        stop_req = 1'b1;
        wait_sig(2, 20, n);
        ackc = 1;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (!stop_ack) break;
            ackc++;
        end
        check("forced len", ackc, MAXS);
        check("forced phi2", int'(phi2_rise), 1);
        wait_sig(1, 20, n);
        wait_sig(0, 20, n);
        check("no restop", n, 3);
        stop_req = 1'b0;
        @(negedge clk);
        stop_req = 1'b1;
        wait_sig(2, 20, n);
        check("restop", int'(stop_ack), 1);
        stop_req = 1'b0;
        wait_sig(0, 20, n);
        check("resume lat", n, 1);
`endif

        // zero half-period behaves as one
        half_period = 8'd0;
        wait_sig(0, 20, n);
        wait_sig(1, 20, n);
        check("hp0 high", n, 1);
        wait_sig(0, 20, n);
        check("hp0 low", n, 1);
        half_period = 8'd1;
        wait_sig(1, 20, n);
        check("hp1 high", n, 1);
        wait_sig(0, 20, n);
        check("hp1 low", n, 1);

        // half-period change mid-phase
        half_period = 8'd4;
        wait_sig(1, 20, n);
        wait_sig(0, 20, n);
        half_period = 8'd2;
        wait_sig(1, 20, n);
        check("mid old", n, 4);
        wait_sig(0, 20, n);
        check("mid new low", n, 2);
        wait_sig(1, 20, n);
        check("mid new high", n, 2);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 asserts, fails);
        $finish;
    end

endmodule
